// File: rtl/sel_collect_pkg.sv
// Shared types and constants for the selector requester/collector.
package sel_pkg;

    localparam int LANES  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_COUNTER = 3'd1,
        SEL_ADDER   = 3'd2,
        SEL_MULT    = 3'd3,
        SEL_ACC     = 3'd4,
        SEL_NONLIN  = 3'd5,
        SEL_KSORT   = 3'd6
    } sel_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // ksort returns K values followed by K indices, packed LANES words per beat
    function automatic int nbeats(input int k);
        return (2 * k + LANES - 1) / LANES;
    endfunction

endpackage

// File: rtl/sel_collect_if.sv
// Request, selector and result signals of sel_collect; order_err exists only
// when SEL_COLLECT_ORDER_CHECK_EN is defined.
interface sel_collect_if
    import sel_pkg::*;
#(
    parameter int K = 20
) ();

    logic                          start;
    logic [2:0]                    mode;
    logic                          busy;
    logic                          err;
    logic [2:0]                    sel_o;
    logic [WORD_W-1:0]             count_o;
    logic [WORD_W-1:0]             in_scalar;
    logic [LANES-1:0][WORD_W-1:0]  in_vector;
    logic                          res_valid;
    logic                          res_ready;
    logic [2:0]                    res_mode;
    logic [WORD_W-1:0]             res_scalar;
    logic [LANES-1:0][WORD_W-1:0]  res_vector;
    logic [K-1:0][WORD_W-1:0]      res_kval;
    logic [K-1:0][WORD_W-1:0]      res_kidx;
`ifdef SEL_COLLECT_ORDER_CHECK_EN
    logic                          order_err;
`endif

    modport slave (
        input  start, mode, in_scalar, in_vector, res_ready,
        output busy, err, sel_o, count_o, res_valid, res_mode,
               res_scalar, res_vector, res_kval, res_kidx
`ifdef SEL_COLLECT_ORDER_CHECK_EN
        , output order_err
`endif
    );

    modport master (
        output start, mode, in_scalar, in_vector, res_ready,
        input  busy, err, sel_o, count_o, res_valid, res_mode,
               res_scalar, res_vector, res_kval, res_kidx
`ifdef SEL_COLLECT_ORDER_CHECK_EN
        , input order_err
`endif
    );

endinterface

// File: rtl/sel_collect_ksort_unpack.sv
// Merges one ksort beat into the value/index arrays: lane l of beat b is flat
// word 16*b+l; the first K words are values, the next K indices, the rest dropped.
module ksort_unpack
    import sel_pkg::*;
#(
    parameter int K = 20
) (
    input  logic [WORD_W-1:0]             i_beat,
    input  logic [LANES-1:0][WORD_W-1:0]  i_lanes,
    input  logic [K-1:0][WORD_W-1:0]      i_kval,
    input  logic [K-1:0][WORD_W-1:0]      i_kidx,
    output logic [K-1:0][WORD_W-1:0]      o_kval,
    output logic [K-1:0][WORD_W-1:0]      o_kidx
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    function automatic int flat_idx(input logic [WORD_W-1:0] beat, input int lane);
        return LANES * int'(beat) + lane;
    endfunction

    always_comb begin
        o_kval = i_kval;
        o_kidx = i_kidx;
        for (int l = 0; l < LANES; l++) begin
            if (flat_idx(i_beat, l) < K)
                o_kval[IW'(flat_idx(i_beat, l))] = i_lanes[l];
            else if (flat_idx(i_beat, l) < 2 * K)
                o_kidx[IW'(flat_idx(i_beat, l) - K)] = i_lanes[l];
        end
    end

endmodule

// File: rtl/sel_collect.sv
// sel_collect: drives the 6-way selector, waits out its latency, collects the
// scalar/vector/ksort result and offers it downstream. Option: SEL_COLLECT_ORDER_CHECK_EN.
module sel_collect
    import sel_pkg::*;
#(
    parameter int K       = 20,
    parameter int SEL_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    sel_collect_if.slave bus
);

    localparam int                NB        = nbeats(K);
    localparam logic [2:0]        WAIT_INIT = 3'(SEL_LAT - 1);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(NB - 1);

    state_e                        r_state;
    logic [2:0]                    r_wait;
    logic [2:0]                    r_sel;
    logic [2:0]                    r_mode;
    logic [WORD_W-1:0]             r_count;
    logic                          r_busy;
    logic                          r_err;
    logic                          r_valid;
    logic [WORD_W-1:0]             r_scalar;
    logic [LANES-1:0][WORD_W-1:0]  r_vector;
    logic [K-1:0][WORD_W-1:0]      r_kval;
    logic [K-1:0][WORD_W-1:0]      r_kidx;
    logic [K-1:0][WORD_W-1:0]      w_kval_nxt;
    logic [K-1:0][WORD_W-1:0]      w_kidx_nxt;

    ksort_unpack #(.K(K)) u_unpack (
        .i_beat  (r_count),
        .i_lanes (bus.in_vector),
        .i_kval  (r_kval),
        .i_kidx  (r_kidx),
        .o_kval  (w_kval_nxt),
        .o_kidx  (w_kidx_nxt)
    );

`ifdef SEL_COLLECT_ORDER_CHECK_EN
    logic r_order_err;

    function automatic logic unsorted(input logic [K-1:0][WORD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < K - 1; i++)
            bad = bad | (v[i] > v[i+1]);
        return bad;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wait   <= '0;
            r_sel    <= '0;
            r_mode   <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_scalar <= '0;
            r_vector <= '0;
            r_kval   <= '0;
            r_kidx   <= '0;
`ifdef SEL_COLLECT_ORDER_CHECK_EN
            r_order_err <= 1'b0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.mode inside {[3'd1:3'd6]}) begin
                            r_state <= ST_ISSUE;
                            r_sel   <= bus.mode;
                            r_mode  <= bus.mode;
                            r_count <= '0;
                            r_wait  <= WAIT_INIT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_wait == 3'd0)
                        r_state <= ST_CAPTURE;
                    else
                        r_wait <= r_wait - 3'd1;
                end
                ST_CAPTURE: begin
                    case (r_mode)
                        SEL_COUNTER, SEL_ADDER, SEL_MULT: r_vector <= bus.in_vector;
                        SEL_ACC, SEL_NONLIN:              r_scalar <= bus.in_scalar;
                        SEL_KSORT: begin
                            r_kval <= w_kval_nxt;
                            r_kidx <= w_kidx_nxt;
                        end
                        default: ;
                    endcase
                    if (r_mode == SEL_KSORT && r_count < LAST_BEAT) begin
                        r_count <= r_count + 1'b1;
                        r_wait  <= WAIT_INIT;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
`ifdef SEL_COLLECT_ORDER_CHECK_EN
                        // judged on the post-capture array so the flag lines up with res_valid
                        r_order_err <= (r_mode == SEL_KSORT) && unsorted(w_kval_nxt);
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_sel   <= '0;
                        r_count <= '0;
`ifdef SEL_COLLECT_ORDER_CHECK_EN
                        r_order_err <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
    assign bus.sel_o      = r_sel;
    assign bus.count_o    = r_count;
    assign bus.res_valid  = r_valid;
    assign bus.res_mode   = r_mode;
    assign bus.res_scalar = r_scalar;
    assign bus.res_vector = r_vector;
    assign bus.res_kval   = r_kval;
    assign bus.res_kidx   = r_kidx;
`ifdef SEL_COLLECT_ORDER_CHECK_EN
    assign bus.order_err  = r_order_err;
`endif

endmodule

// File: tb/tb_sel_collect.sv
// Bench for sel_collect: a latency-accurate selector model serves data from
// per-transaction tables; results are predicted from the flat-word rules.
module tb_sel_collect;
    import sel_pkg::*;

    localparam int K       = 20;
    localparam int SEL_LAT = 1;
    localparam int NB      = nbeats(K);
    localparam int NFLAT   = NB * LANES;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] tbl  [NFLAT];
    logic [31:0] vtbl [LANES];
    logic [31:0] sval;

    sel_collect_if #(.K(K)) bus ();

    sel_collect #(.K(K), .SEL_LAT(SEL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // selector: output reflects sel/count presented SEL_LAT cycles earlier
    logic [2:0]  pipe_sel [SEL_LAT];
    logic [31:0] pipe_cnt [SEL_LAT];

    always @(posedge clk) begin
        pipe_sel[0] <= bus.sel_o;
        pipe_cnt[0] <= bus.count_o;
        for (int i = 1; i < SEL_LAT; i++) begin
            pipe_sel[i] <= pipe_sel[i-1];
            pipe_cnt[i] <= pipe_cnt[i-1];
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (pipe_sel[SEL_LAT-1] >= 3'd1 && pipe_sel[SEL_LAT-1] <= 3'd3)
                bus.in_vector[l] = vtbl[l];
            else if (pipe_sel[SEL_LAT-1] == 3'd6 && pipe_cnt[SEL_LAT-1] < NB)
                bus.in_vector[l] = tbl[int'(pipe_cnt[SEL_LAT-1]) * LANES + l];
            else
                bus.in_vector[l] = 32'hDEAD_0000 | 32'(l);
        end
        if (pipe_sel[SEL_LAT-1] == 3'd4 || pipe_sel[SEL_LAT-1] == 3'd5)
            bus.in_scalar = sval;
        else
            bus.in_scalar = 32'hBAD0_0000;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_result(input logic [2:0] m, input string ph);
        chk({ph, " res_mode"}, 32'(bus.res_mode), 32'(m));
        if (m >= 3'd1 && m <= 3'd3) begin
            for (int l = 0; l < LANES; l++)
                chk($sformatf("%s res_vector[%0d]", ph, l), bus.res_vector[l], vtbl[l]);
        end else if (m == 3'd4 || m == 3'd5) begin
            chk({ph, " res_scalar"}, bus.res_scalar, sval);
        end else begin
            for (int i = 0; i < K; i++) begin
                chk($sformatf("%s res_kval[%0d]", ph, i), bus.res_kval[i], tbl[i]);
                chk($sformatf("%s res_kidx[%0d]", ph, i), bus.res_kidx[i], tbl[K + i]);
            end
        end
`ifdef SEL_COLLECT_ORDER_CHECK_EN
        begin
            logic exp_ord;
            exp_ord = 1'b0;
            if (m == 3'd6)
                for (int i = 0; i < K - 1; i++)
                    if (tbl[i] > tbl[i+1]) exp_ord = 1'b1;
            chk({ph, " order_err"}, 32'(bus.order_err), 32'(exp_ord));
        end
`endif
    endtask

    task automatic fill_random();
        for (int f = 0; f < NFLAT; f++) tbl[f] = $urandom;
        for (int l = 0; l < LANES; l++) vtbl[l] = $urandom;
        sval = $urandom;
    endtask

    // start accepted at edge 0; cycle n is the interval after edge n
    task automatic run_txn(input logic [2:0] m, input int stall, input bit poke);
        int          cyc;
        int          exp_lat;
        int          sel_bad;
        int          err_seen;
        int          drop;
        logic [31:0] cnt_q[$];

        sel_bad  = 0;
        err_seen = 0;
        drop     = 0;
        exp_lat  = ((m == 3'd6) ? NB : 1) * (SEL_LAT + 1) + 1;

        @(negedge clk);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        cnt_q.push_back(bus.count_o);
        while (!bus.res_valid && cyc < 64) begin
            if (bus.sel_o !== m || bus.busy !== 1'b1) sel_bad++;
            if (bus.err !== 1'b0) err_seen++;
            if (bus.count_o !== cnt_q[$]) cnt_q.push_back(bus.count_o);
            if (poke) begin
                bus.start = 1'b1;
                bus.mode  = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            cyc++;
        end
        chk("valid_latency", 32'(cyc), 32'(exp_lat));
        chk("beat_count", 32'(cnt_q.size()), 32'((m == 3'd6) ? NB : 1));
        foreach (cnt_q[i]) chk($sformatf("count_o step %0d", i), cnt_q[i], 32'(i));
        check_result(m, "at_valid");

        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.start = 1'b1;
                bus.mode  = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            if (bus.res_valid !== 1'b1) drop++;
            if (bus.sel_o !== m || bus.busy !== 1'b1) sel_bad++;
            if (bus.err !== 1'b0) err_seen++;
        end
        if (stall > 0) begin
            chk("valid_held", 32'(drop), 32'd0);
            check_result(m, "after_stall");
        end
        chk("sel_busy_stable", 32'(sel_bad), 32'd0);
        chk("no_err_pulse", 32'(err_seen), 32'd0);

        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("post_hs res_valid", 32'(bus.res_valid), 32'd0);
        chk("post_hs busy", 32'(bus.busy), 32'd0);
        chk("post_hs sel_o", 32'(bus.sel_o), 32'd0);
        chk("post_hs count_o", bus.count_o, 32'd0);
`ifdef SEL_COLLECT_ORDER_CHECK_EN
        chk("post_hs order_err", 32'(bus.order_err), 32'd0);
`endif
    endtask

    initial begin
        int guard;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 3'd0;
        bus.res_ready = 1'b0;
        for (int f = 0; f < NFLAT; f++) tbl[f] = 32'hA000 + 32'(f);
        for (int l = 0; l < LANES; l++) vtbl[l] = 32'h100 + 32'(l);
        sval = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst sel_o", 32'(bus.sel_o), 32'd0);
        chk("rst count_o", bus.count_o, 32'd0);
        chk("rst res_scalar", bus.res_scalar, 32'd0);
        chk("rst res_kval[0]", bus.res_kval[0], 32'd0);
        rst = 1'b0;

        // directed cases from the flat-word and lane rules
        run_txn(3'd2, 0, 1'b0);
        run_txn(3'd6, 0, 1'b0);
        sval = 32'h1234_5678;
        run_txn(3'd4, 5, 1'b1);

        foreach (pipe_sel[i]) ;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.mode  = (k == 0) ? 3'd7 : 3'd0;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            chk("illegal err", 32'(bus.err), 32'd1);
            chk("illegal busy", 32'(bus.busy), 32'd0);
            chk("illegal sel_o", 32'(bus.sel_o), 32'd0);
            @(negedge clk);
            chk("illegal err_one_cycle", 32'(bus.err), 32'd0);
            chk("illegal busy_later", 32'(bus.busy), 32'd0);
        end

        // reset during beat 1 of a ksort, then a clean ksort
        fill_random();
        @(negedge clk);
        bus.mode  = 3'd6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.count_o !== 32'd1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_beat1", 32'(bus.count_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst sel_o", 32'(bus.sel_o), 32'd0);
        chk("midrst count_o", bus.count_o, 32'd0);
        chk("midrst res_kval[0]", bus.res_kval[0], 32'd0);
        rst = 1'b0;
        run_txn(3'd6, 1, 1'b0);

`ifdef SEL_COLLECT_ORDER_CHECK_EN
        for (int f = 0; f < NFLAT; f++) tbl[f] = 32'hA000 + 32'(f);
        run_txn(3'd6, 0, 1'b0);
        fill_random();
        for (int i = 0; i < K; i++) tbl[i] = 32'(i);
        tbl[5] = 32'd9;
        tbl[6] = 32'd3;
        run_txn(3'd6, 0, 1'b0);
`endif

        for (int t = 0; t < 16; t++) begin
            fill_random();
            run_txn(3'($urandom_range(1, 6)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
